// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle instruction sequencer. Steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB (plus WB2 for the two-phase swap) and
// drives every datapath strobe for the current cycle.
//
// Ports:
//   Clk, Reset_n        clock (rising edge), asynchronous active-low reset
//   start               leave IDLE and begin fetching
//   instr, func         opcode / function field, sampled at end of FETCH
//   zero                ALU equality flag (used by BEQ in EXEC)
//   mem_ready           data memory completes its access this cycle (MEM only)
//   halt_req            stop instead of fetching
//   PCWrite..RegWrite   PC/IR/datapath control strobes
//   ALUOp               latched opcode in EXEC/MEM/WB, all-ones otherwise
//   busy, done, mem_err status flags
//   instr_cnt           retired-instruction counter (wraps)
module multicycle_control #(
  parameter int OPWIDTH     = 3,
  parameter int MCODEBITS   = 3,
  parameter int CNTW        = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic [MCODEBITS-1:0] instr,
  input  logic [1:0]           func,
  input  logic                 zero,
  input  logic                 mem_ready,
  input  logic                 halt_req,
  output logic                 PCWrite,
  output logic                 PCSrcBr,
  output logic                 PCSrcJmp,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 LS,
  output logic                 iSig,
  output logic                 SwapPhase,
  output logic                 MemtoReg,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_err,
  output logic [CNTW-1:0]      instr_cnt
);

  localparam logic [MCODEBITS-1:0] OP_BEQ   = MCODEBITS'(1);
  localparam logic [MCODEBITS-1:0] OP_LOAD  = MCODEBITS'(4);
  localparam logic [MCODEBITS-1:0] OP_STORE = MCODEBITS'(5);
  localparam logic [MCODEBITS-1:0] OP_JUMP  = MCODEBITS'(6);
  localparam logic [MCODEBITS-1:0] OP_ITYPE = MCODEBITS'(7);
  localparam logic [1:0]           FN_SWAP  = 2'b10;

  localparam int              WW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0]   WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_WB2, S_HALT
  } state_t;

  // ERR needs its own encoding; 8 states above fill 3 bits, so widen.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_WB2    = 4'd6,
    ST_HALT   = 4'd7,
    ST_ERR    = 4'd8
  } fsm_t;

  fsm_t                 state, next_state;
  logic [MCODEBITS-1:0] op_q;
  logic [1:0]           func_q;
  logic [WW-1:0]        wait_q;
  logic                 retire, wait_clr, wait_inc, is_load, is_swap;

  assign is_load = (op_q == OP_LOAD);
  assign is_swap = (op_q == OP_ITYPE) && (func_q == FN_SWAP);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      func_q    <= '0;
      wait_q    <= '0;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      // Opcode/func captured only on the FETCH->DECODE edge
      if (state == ST_FETCH && !halt_req) begin
        op_q   <= instr;
        func_q <= func;
      end
      if (wait_clr)      wait_q <= '0;
      else if (wait_inc) wait_q <= wait_q + 1'b1;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    PCWrite    = 1'b0;
    PCSrcBr    = 1'b0;
    PCSrcJmp   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    LS         = 1'b0;
    iSig       = 1'b0;
    SwapPhase  = 1'b0;
    MemtoReg   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    ALUOp      = {OPWIDTH{1'b1}};
    busy       = 1'b0;
    done       = 1'b0;
    mem_err    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        busy = 1'b1;
        if (halt_req) begin
          next_state = ST_HALT;
        end else begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        busy       = 1'b1;
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        busy  = 1'b1;
        ALUOp = OPWIDTH'(op_q);
        if (op_q == OP_BEQ) begin
          ALUSrc     = 1'b1;
          PCWrite    = zero;
          PCSrcBr    = zero;
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else if (op_q == OP_JUMP) begin
          PCWrite    = 1'b1;
          PCSrcJmp   = 1'b1;
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
          ALUSrc     = 1'b1;
          wait_clr   = 1'b1;
          next_state = ST_MEM;
        end else begin
          RegDst     = 1'b1;
          iSig       = (op_q == OP_ITYPE) && !is_swap;
          next_state = ST_WB;
        end
      end
      ST_MEM: begin
        busy     = 1'b1;
        ALUOp    = OPWIDTH'(op_q);
        ALUSrc   = 1'b1;
        MemRead  = is_load;
        LS       = is_load;
        MemWrite = !is_load;
        // Ready wins over timeout when both land on the same cycle
        if (mem_ready) begin
          next_state = is_load ? ST_WB : ST_FETCH;
          retire     = !is_load;
        end else if (wait_q == WAIT_LAST) begin
          next_state = ST_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_WB: begin
        busy     = 1'b1;
        ALUOp    = OPWIDTH'(op_q);
        RegWrite = 1'b1;
        MemtoReg = is_load;
        LS       = is_load;
        RegDst   = !is_load;
        if (is_swap) begin
          next_state = ST_WB2;
        end else begin
          retire     = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_WB2: begin
        busy       = 1'b1;
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        SwapPhase  = 1'b1;
        retire     = 1'b1;
        next_state = ST_FETCH;
      end
      ST_HALT: begin
        done = 1'b1;
      end
      ST_ERR: begin
        mem_err = 1'b1;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       Clk, Reset_n, start, zero, mem_ready, halt_req;
  logic [2:0] instr;
  logic [1:0] func;
  logic       PCWrite, PCSrcBr, PCSrcJmp, IRWrite, RegDst, LS, iSig, SwapPhase;
  logic       MemtoReg, MemRead, MemWrite, ALUSrc, RegWrite, busy, done, mem_err;
  logic [2:0] ALUOp;
  logic [1:0] instr_cnt;

  multicycle_control #(
    .OPWIDTH(3), .MCODEBITS(3), .CNTW(2), .MEM_TIMEOUT(8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .instr(instr), .func(func),
    .zero(zero), .mem_ready(mem_ready), .halt_req(halt_req),
    .PCWrite(PCWrite), .PCSrcBr(PCSrcBr), .PCSrcJmp(PCSrcJmp), .IRWrite(IRWrite),
    .RegDst(RegDst), .LS(LS), .iSig(iSig), .SwapPhase(SwapPhase),
    .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .busy(busy), .done(done), .mem_err(mem_err), .instr_cnt(instr_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // strobe bit positions: PCW BR JMP IRW RD LS ISIG SWP M2R MRD MWR ASR RW
  localparam logic [12:0] NONE = 13'h0000;
  localparam logic [12:0] PCW  = 13'h1000;
  localparam logic [12:0] BR   = 13'h0800;
  localparam logic [12:0] JMP  = 13'h0400;
  localparam logic [12:0] IRW  = 13'h0200;
  localparam logic [12:0] RD   = 13'h0100;
  localparam logic [12:0] LSB  = 13'h0080;
  localparam logic [12:0] ISG  = 13'h0040;
  localparam logic [12:0] SWP  = 13'h0020;
  localparam logic [12:0] M2R  = 13'h0010;
  localparam logic [12:0] MRD  = 13'h0008;
  localparam logic [12:0] MWR  = 13'h0004;
  localparam logic [12:0] ASR  = 13'h0002;
  localparam logic [12:0] RW   = 13'h0001;
  // status {busy, done, mem_err}
  localparam logic [2:0]  IDL  = 3'b000;
  localparam logic [2:0]  BSY  = 3'b100;
  localparam logic [2:0]  DON  = 3'b010;
  localparam logic [2:0]  ERS  = 3'b001;

  logic [20:0] exp_q[$];
  string       name_q[$];
  logic [20:0] got;
  logic [1:0]  exp_cnt;
  int          checks = 0;
  int          errors = 0;
  bit          drain_req = 0;
  bit          drain_done = 0;

  assign got = {PCWrite, PCSrcBr, PCSrcJmp, IRWrite, RegDst, LS, iSig, SwapPhase,
                MemtoReg, MemRead, MemWrite, ALUSrc, RegWrite, ALUOp,
                busy, done, mem_err, instr_cnt};

  // Monitor: compares the DUT against the next queued expectation each cycle
  always @(negedge Clk) begin
    logic [20:0] e;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got strobes=%b alu=%b st=%b cnt=%0d, want strobes=%b alu=%b st=%b cnt=%0d",
                 n, got[20:8], got[7:5], got[4:2], got[1:0], e[20:8], e[7:5], e[4:2], e[1:0]);
      end
    end else if (drain_req && !drain_done) begin
      drain_done = 1;
      checks++;
      if (name_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d names left, want 0", name_q.size());
      end
    end
  end

  task automatic chk(input string n, input logic [12:0] s, input logic [2:0] alu,
                     input logic [2:0] st, input bit ret);
    exp_q.push_back({s, alu, st, exp_cnt});
    name_q.push_back(n);
    @(posedge Clk);
    #1;
    if (ret) exp_cnt = exp_cnt + 2'd1;
  endtask

  task automatic fd(input string n);
    chk({n, "_fetch"}, PCW | IRW, 3'd7, BSY, 0);
    chk({n, "_decode"}, NONE, 3'd7, BSY, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 0; start = 0; instr = 0; func = 0; zero = 0; mem_ready = 0; halt_req = 0;
    exp_cnt = 0;
    @(posedge Clk); #1;
    chk("reset_state", NONE, 3'd7, IDL, 0);
    Reset_n = 1; start = 1;
    chk("idle_start", NONE, 3'd7, IDL, 0);
    start = 0;

    // R-type; instr changes after FETCH must be ignored
    instr = 3'd0; func = 2'd0;
    chk("r_fetch", PCW | IRW, 3'd7, BSY, 0);
    instr = 3'd6;
    chk("r_decode", NONE, 3'd7, BSY, 0);
    instr = 3'd4;
    chk("r_exec", RD, 3'd0, BSY, 0);
    chk("r_wb", RW | RD, 3'd0, BSY, 1);

    // BEQ taken then not taken
    instr = 3'd1;
    fd("beq1");
    zero = 1;
    chk("beq1_exec", ASR | PCW | BR, 3'd1, BSY, 1);
    zero = 0;
    fd("beq0");
    chk("beq0_exec", ASR, 3'd1, BSY, 1);

    // LOAD, ready after 3 wait cycles
    instr = 3'd4;
    fd("ld");
    chk("ld_exec", ASR, 3'd4, BSY, 0);
    for (int i = 0; i < 3; i++) chk("ld_mem_wait", ASR | MRD | LSB, 3'd4, BSY, 0);
    mem_ready = 1;
    chk("ld_mem_rdy", ASR | MRD | LSB, 3'd4, BSY, 0);
    mem_ready = 0;
    chk("ld_wb", RW | M2R | LSB, 3'd4, BSY, 1);

    // STORE, ready on the 8th MEM cycle: ready beats timeout
    instr = 3'd5;
    fd("st");
    chk("st_exec", ASR, 3'd5, BSY, 0);
    for (int i = 0; i < 7; i++) chk("st_mem_wait", ASR | MWR, 3'd5, BSY, 0);
    mem_ready = 1;
    chk("st_mem_rdy8", ASR | MWR, 3'd5, BSY, 1);
    mem_ready = 0;

    // SWAP then I-type
    instr = 3'd7; func = 2'b10;
    fd("swap");
    chk("swap_exec", RD, 3'd7, BSY, 0);
    chk("swap_wb", RW | RD, 3'd7, BSY, 0);
    chk("swap_wb2", RW | RD | SWP, 3'd7, BSY, 1);
    func = 2'b01;
    fd("itype");
    chk("itype_exec", RD | ISG, 3'd7, BSY, 0);
    chk("itype_wb", RW | RD, 3'd7, BSY, 1);

    // STORE timeout -> sticky ERR
    instr = 3'd5; func = 2'b00;
    fd("sto");
    chk("sto_exec", ASR, 3'd5, BSY, 0);
    for (int i = 0; i < 8; i++) chk("sto_mem_wait", ASR | MWR, 3'd5, BSY, 0);
    start = 1; mem_ready = 1;
    for (int i = 0; i < 3; i++) chk("err_sticky", NONE, 3'd7, ERS, 0);
    start = 0; mem_ready = 0;

    // Reset from ERR, then 5 JUMPs wrap the 2-bit counter; mem_ready ignored outside MEM
    Reset_n = 0; exp_cnt = 0;
    chk("err_reset", NONE, 3'd7, IDL, 0);
    Reset_n = 1; start = 1;
    chk("idle_start2", NONE, 3'd7, IDL, 0);
    start = 0; instr = 3'd6; mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      fd("jmp");
      chk("jmp_exec", PCW | JMP, 3'd6, BSY, 1);
    end
    mem_ready = 0;

    // Reset pulse in the middle of a LOAD MEM cycle
    instr = 3'd4;
    fd("ldr");
    chk("ldr_exec", ASR, 3'd4, BSY, 0);
    chk("ldr_mem", ASR | MRD | LSB, 3'd4, BSY, 0);
    Reset_n = 0; exp_cnt = 0;
    chk("ldr_async_reset", NONE, 3'd7, IDL, 0);
    Reset_n = 1; start = 1;
    chk("idle_start3", NONE, 3'd7, IDL, 0);
    start = 0;

    // Halt request in FETCH
    instr = 3'd0; halt_req = 1;
    chk("halt_fetch", NONE, 3'd7, BSY, 0);
    halt_req = 0; start = 1;
    for (int i = 0; i < 3; i++) chk("halt_hold", NONE, 3'd7, DON, 0);
    start = 0;

    drain_req = 1;
    repeat (2) @(posedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states with a state machine. Additions over the single-cycle decoder:
- memory ready/wait handshake with timeout;
- two-phase register swap;
- halt state;
- retired-instruction counter.

It sits between the instruction register and the datapath, and drives every datapath control strobe per cycle.

## Interface
Parameters:
- OPWIDTH, 3, ALUOp width
- MCODEBITS, 3, opcode width
- CNTW, 16, retired-instruction counter width
- MEM_TIMEOUT, 8, maximum MEM cycles without mem_ready before error (≥1)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching
- instr  in  MCODEBITS  opcode from instruction memory, valid in FETCH
- func  in  2  function field, valid in FETCH
- zero  in  1  ALU equality flag, valid in EXEC
- mem_ready  in  1  data memory completes access this cycle
- halt_req  in  1  stop before next fetch
- PCWrite, PCSrcBr, PCSrcJmp, IRWrite  out  1 each  PC/IR strobes
- RegDst, LS, iSig, SwapPhase, MemtoReg, MemRead, MemWrite, ALUSrc, RegWrite  out  1 each  datapath controls
- ALUOp  out  OPWIDTH  ALU operation
- busy, done, mem_err  out  1 each  status
- instr_cnt  out  CNTW  retired instructions

## Operation
- Opcode and func are latched into internal registers at the FETCH→DECODE edge. Later changes on `instr`/`func` are ignored until the next FETCH.
- Opcode encoding:
  - 000 R-type
  - 001 BEQ
  - 010 SRL
  - 011 SLL
  - 100 LOAD
  - 101 STORE
  - 110 JUMP
  - 111 I-type; with func=10 it is SWAP
- ALUOp equals the latched opcode in EXEC, MEM and WB, and is 3'b111 otherwise.
- Every output not listed as asserted in a state is 0.

State transitions and per-state outputs:
- **IDLE**
  - busy=0.
  - start=1 → FETCH.
- **FETCH**
  - If halt_req=1 → HALT, with no strobes asserted.
  - Else IRWrite=1, PCWrite=1 (PC+1) → DECODE.
- **DECODE**
  - Internal registers load; no strobes.
  - → EXEC.
- **EXEC**
  - R/SRL/SLL/I-type/SWAP: RegDst=1; iSig=1 for I-type non-swap → WB.
  - BEQ: ALUSrc=1; PCWrite=PCSrcBr=zero (Mealy on zero) → FETCH; retires.
  - JUMP: PCWrite=1, PCSrcJmp=1 → FETCH; retires.
  - LOAD/STORE: ALUSrc=1 → MEM; the wait counter clears.
- **MEM**
  - ALUSrc=1.
  - LOAD: MemRead=1, LS=1.
  - STORE: MemWrite=1.
  - Strobes are held until mem_ready=1.
  - mem_ready=1 → WB (LOAD) or FETCH (STORE, retires).
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT-1 with mem_ready=0 → ERR.
  - mem_ready has priority over timeout in the same cycle.
- **WB**
  - RegWrite=1.
  - LOAD: MemtoReg=1, LS=1.
  - Non-LOAD: RegDst=1.
  - SWAP: SwapPhase=0 → WB2.
  - All others → FETCH; retires.
- **WB2**
  - RegWrite=1, RegDst=1, SwapPhase=1.
  - → FETCH; retires.
- **HALT**
  - done=1, busy=0.
  - Held until reset; start is ignored.
- **ERR**
  - mem_err=1, busy=0.
  - Sticky until reset.

Counter and status rules:
- busy=1 in FETCH, DECODE, EXEC, MEM, WB and WB2.
- "Retires" means instr_cnt increments by 1 on that edge, with modular wrap at 2^CNTW (all-ones → 0).

## Timing
Reset (Reset_n=0, immediate and asynchronous):
- State goes to IDLE.
- instr_cnt=0, wait counter=0, latched opcode=000, func=00.
- All outputs 0 except ALUOp=3'b111.
- Reset asserted mid-instruction aborts it with no retirement.

Cycles per instruction, counted from FETCH entry to the next FETCH entry:
- BEQ/JUMP: 3
- R/SRL/SLL/I-type: 4
- SWAP: 5
- STORE: 4+w
- LOAD: 5+w
- w = MEM cycles before the one with mem_ready=1 (w=0 when ready on first MEM cycle).

Handshake and counter timing:
- mem_ready is sampled only in MEM; it is ignored elsewhere.
- Timeout occurs after exactly MEM_TIMEOUT MEM cycles without ready.
- instr_cnt updates on the same edge as the transition out of the retiring state.

## Test plan
- Reset → start, R-type (000): IRWrite/PCWrite in cycle 1, RegWrite only in cycle 4, instr_cnt=1 after cycle 4; changing `instr` during EXEC has no effect.
- BEQ with zero=1, then BEQ with zero=0 → PCWrite=PCSrcBr=1 in the first EXEC, PCWrite=0 in the second; RegWrite never 1; instr_cnt=2 after 6 cycles.
- LOAD with mem_ready delayed 3 cycles → MemRead held 4 MEM cycles, then WB with MemtoReg=1, RegWrite=1; total 8 cycles; instr_cnt=1.
- STORE with MEM_TIMEOUT=8 and mem_ready stuck at 0 → ERR after 8 MEM cycles, mem_err=1 sticky, busy=0, instr_cnt unchanged; mem_ready=1 exactly on the 8th cycle instead → FETCH, no error.
- SWAP (111, func=10) → two RegWrite cycles with SwapPhase 0 then 1; total 5 cycles; followed by I-type func=01 → iSig=1 in EXEC.
- halt_req=1 during FETCH → HALT next cycle with no IRWrite, done=1; start ignored; Reset_n pulse mid-LOAD (in MEM) → immediate IDLE, all outputs at reset values, instr_cnt=0; CNTW=2 with 5 JUMPs → instr_cnt wraps to 1.
